// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register with writeback-source select.
//
// The writeback data is chosen when the entry is captured:
//   wb_sel 00 = alu_out, 01 = mem_data, 10 = pc_next (link), 11 = imm_data.
// A link write (wb_sel 10) always targets LINK_REG.
//
// A held (stalled) entry writes the register file only once. The presented
// flag marks an entry that has already been visible for a cycle.
// A retired HALT sets the sticky wb_halted flag, which stays set until rst.
//
// Optional feature, enabled with `define WB_RETIRE_COUNT_EN:
//   retire_count counts retire events and saturates at all-ones.
//   When the macro is not defined, retire_count is tied to zero.
//
// LINK_REG must fit in REG_ADDR_W bits.

module writeback_stage #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned LINK_REG   = 7,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic [DATA_W-1:0]     pc_next,
    input  logic [DATA_W-1:0]     imm_data,
    input  logic [1:0]            wb_sel,
    input  logic                  reg_wr_in,
    input  logic [REG_ADDR_W-1:0] wr_reg_in,
    input  logic                  halt_in,
    output logic                  wb_valid,
    output logic                  wb_reg_wr_en,
    output logic [REG_ADDR_W-1:0] wb_wr_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_halted,
    output logic [CNT_W-1:0]      retire_count
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;
    localparam logic [1:0] SEL_IMM  = 2'b11;

    logic                  valid_q,     valid_d;
    logic [DATA_W-1:0]     data_q,      data_d;
    logic [REG_ADDR_W-1:0] wr_reg_q,    wr_reg_d;
    logic                  reg_wr_q,    reg_wr_d;
    logic                  halt_q,      halt_d;
    logic                  presented_q, presented_d;
    logic                  halted_q,    halted_d;

    logic [DATA_W-1:0]     cap_data;
    logic [REG_ADDR_W-1:0] cap_wr_reg;
    logic                  retire;
    logic                  halting;

    // Resolve the writeback source at capture time.
    always_comb begin
        cap_data   = alu_out;
        cap_wr_reg = wr_reg_in;
        case (wb_sel)
            SEL_ALU:  cap_data = alu_out;
            SEL_MEM:  cap_data = mem_data;
            SEL_LINK: begin
                cap_data   = pc_next;
                cap_wr_reg = REG_ADDR_W'(LINK_REG);
            end
            SEL_IMM:  cap_data = imm_data;
            default:  cap_data = alu_out;
        endcase
    end

    // The retire event is taken from current state only, so a flush arriving
    // in a HALT's retire cycle cannot undo that retire.
    // halting includes the retiring HALT itself, which keeps the
    // instruction behind the HALT from being loaded on the same edge.
    assign retire  = valid_q & ~presented_q;
    assign halting = halted_q | (retire & halt_q);

    // Next-state selection with priority flush > halted > stall > load.
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        wr_reg_d    = wr_reg_q;
        reg_wr_d    = reg_wr_q;
        halt_d      = halt_q;
        presented_d = presented_q;
        halted_d    = halting;
        if (flush) begin
            valid_d     = 1'b0;
            presented_d = 1'b0;
        end else if (halting) begin
            valid_d     = 1'b0;
            presented_d = 1'b0;
        end else if (stall) begin
            presented_d = presented_q | valid_q;
        end else begin
            valid_d     = in_valid;
            data_d      = cap_data;
            wr_reg_d    = cap_wr_reg;
            reg_wr_d    = reg_wr_in;
            halt_d      = halt_in;
            presented_d = 1'b0;
        end
    end

    // Pipeline register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            wr_reg_q    <= '0;
            reg_wr_q    <= 1'b0;
            halt_q      <= 1'b0;
            presented_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            wr_reg_q    <= wr_reg_d;
            reg_wr_q    <= reg_wr_d;
            halt_q      <= halt_d;
            presented_q <= presented_d;
            halted_q    <= halted_d;
        end
    end

    assign wb_valid     = valid_q;
    assign wb_reg_wr_en = valid_q & reg_wr_q & ~presented_q;
    assign wb_wr_reg    = wr_reg_q;
    assign wb_data      = data_q;
    assign wb_halted    = halted_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating retire counter; a flush does not affect it.
    always_comb begin
        cnt_d = cnt_q;
        if (retire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_count = cnt_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage. The stimulus process pushes the
// hand-computed expected outputs for each clock edge. A monitor running on
// the falling edge pops each entry and compares it with the DUT outputs.

module tb_writeback_stage;

`ifdef WB_RETIRE_COUNT_EN
    localparam int CNT_W  = 4;
    localparam bit CNT_EN = 1'b1;
`else
    localparam int CNT_W  = 16;
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic        wr_en;
        logic [2:0]  wr_reg;
        logic [15:0] data;
        logic        chk_data;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, stall, flush;
    logic [15:0]      alu_out, mem_data, pc_next, imm_data;
    logic [1:0]       wb_sel;
    logic             reg_wr_in;
    logic [2:0]       wr_reg_in;
    logic             halt_in;
    logic             wb_valid, wb_reg_wr_en, wb_halted;
    logic [2:0]       wb_wr_reg;
    logic [15:0]      wb_data;
    logic [CNT_W-1:0] retire_count;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    writeback_stage #(
        .DATA_W(16), .REG_ADDR_W(3), .LINK_REG(7), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_out(alu_out), .mem_data(mem_data), .pc_next(pc_next), .imm_data(imm_data),
        .wb_sel(wb_sel), .reg_wr_in(reg_wr_in), .wr_reg_in(wr_reg_in), .halt_in(halt_in),
        .wb_valid(wb_valid), .wb_reg_wr_en(wb_reg_wr_en), .wb_wr_reg(wb_wr_reg),
        .wb_data(wb_data), .wb_halted(wb_halted), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare DUT outputs with the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("wb_valid",     32'(wb_valid),     32'(e.valid));
            check("wb_reg_wr_en", 32'(wb_reg_wr_en), 32'(e.wr_en));
            check("wb_halted",    32'(wb_halted),    32'(e.halted));
            check("retire_count", 32'(retire_count), CNT_EN ? e.cnt : 32'd0);
            if (e.chk_data) begin
                check("wb_wr_reg", 32'(wb_wr_reg), 32'(e.wr_reg));
                check("wb_data",   32'(wb_data),   32'(e.data));
            end
        end
    end

    task automatic cyc(input logic r, input logic v, input logic s, input logic f,
                       input logic [1:0] sel, input logic rw, input logic [2:0] wr,
                       input logic h,
                       input logic e_valid, input logic e_wren, input logic [2:0] e_wr,
                       input logic [15:0] e_data, input logic e_chk, input logic e_halt,
                       input int e_cnt);
        exp_t e;
        rst = r; in_valid = v; stall = s; flush = f;
        wb_sel = sel; reg_wr_in = rw; wr_reg_in = wr; halt_in = h;
        e.valid = e_valid; e.wr_en = e_wren; e.wr_reg = e_wr; e.data = e_data;
        e.chk_data = e_chk; e.halted = e_halt; e.cnt = 32'(e_cnt);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        alu_out = '0; mem_data = '0; pc_next = '0; imm_data = '0;
        wb_sel = 2'b00; reg_wr_in = 1'b0; wr_reg_in = '0; halt_in = 1'b0;

        // Reset held for two cycles under random inputs.
        for (int i = 0; i < 2; i++) begin
            alu_out = 16'($urandom); mem_data = 16'($urandom);
            pc_next = 16'($urandom); imm_data = 16'($urandom);
            cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                1'($urandom), 3'($urandom), 1'($urandom),
                0, 0, 3'd0, 16'h0000, 1, 0, 0);
        end

        // Source select sweep.
        alu_out = 16'h1111; mem_data = 16'h2222; pc_next = 16'h0044; imm_data = 16'hFFF0;
        cyc(0, 1, 0, 0, 2'b00, 1, 3'd3, 0,  1, 1, 3'd3, 16'h1111, 1, 0, 0);
        cyc(0, 1, 0, 0, 2'b01, 1, 3'd3, 0,  1, 1, 3'd3, 16'h2222, 1, 0, 1);
        cyc(0, 1, 0, 0, 2'b10, 1, 3'd3, 0,  1, 1, 3'd7, 16'h0044, 1, 0, 2);
        cyc(0, 1, 0, 0, 2'b11, 1, 3'd3, 0,  1, 1, 3'd3, 16'hFFF0, 1, 0, 3);

        // Stall hold: one write, stable data for four cycles, one retire.
        alu_out = 16'hBEEF;
        cyc(0, 1, 0, 0, 2'b00, 1, 3'd2, 0,  1, 1, 3'd2, 16'hBEEF, 1, 0, 4);
        alu_out = 16'h1234;
        cyc(0, 1, 1, 0, 2'b00, 1, 3'd5, 0,  1, 0, 3'd2, 16'hBEEF, 1, 0, 5);
        cyc(0, 1, 1, 0, 2'b00, 1, 3'd5, 0,  1, 0, 3'd2, 16'hBEEF, 1, 0, 5);
        cyc(0, 1, 1, 0, 2'b00, 1, 3'd5, 0,  1, 0, 3'd2, 16'hBEEF, 1, 0, 5);

        // Flush beats stall; the next load is normal; then a bubble.
        cyc(0, 1, 1, 1, 2'b00, 1, 3'd5, 0,  0, 0, 3'd0, 16'h0000, 0, 0, 5);
        cyc(0, 1, 0, 0, 2'b01, 1, 3'd5, 0,  1, 1, 3'd5, 16'h2222, 1, 0, 5);
        cyc(0, 0, 0, 0, 2'b01, 1, 3'd5, 0,  0, 0, 3'd0, 16'h0000, 0, 0, 6);

        // HALT without a write, then five ALU writes that must be ignored.
        alu_out = 16'h1111;
        cyc(0, 1, 0, 0, 2'b00, 0, 3'd1, 1,  1, 0, 3'd1, 16'h1111, 1, 0, 6);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0, 2'b00, 1, 3'd4, 0,  0, 0, 3'd0, 16'h0000, 0, 1, 7);
        end
        cyc(1, 0, 0, 0, 2'b00, 0, 3'd0, 0,  0, 0, 3'd0, 16'h0000, 1, 0, 0);

        // Reset during a stall discards the held entry.
        alu_out = 16'h5A5A;
        cyc(0, 1, 0, 0, 2'b00, 1, 3'd6, 0,  1, 1, 3'd6, 16'h5A5A, 1, 0, 0);
        cyc(1, 1, 1, 0, 2'b00, 1, 3'd6, 0,  0, 0, 3'd0, 16'h0000, 1, 0, 0);

        // A flush in a HALT's retire cycle still sets halted.
        alu_out = 16'hABCD;
        cyc(0, 1, 0, 0, 2'b00, 1, 3'd6, 1,  1, 1, 3'd6, 16'hABCD, 1, 0, 0);
        cyc(0, 1, 0, 1, 2'b00, 1, 3'd6, 0,  0, 0, 3'd0, 16'h0000, 0, 1, 1);
        cyc(1, 0, 0, 0, 2'b00, 0, 3'd0, 0,  0, 0, 3'd0, 16'h0000, 1, 0, 0);

        // Twenty back-to-back retires; the 4-bit counter build saturates at 15.
        for (int k = 1; k <= 20; k++) begin
            alu_out = 16'(k);
            cyc(0, 1, 0, 0, 2'b00, 1, 3'd4, 0,  1, 1, 3'd4, 16'(k), 1, 0,
                (k - 1 > 15) ? 15 : k - 1);
        end
        cyc(0, 0, 0, 0, 2'b00, 0, 3'd0, 0,  0, 0, 3'd0, 16'h0000, 0, 0, 15);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Parametrised MEM/WB pipeline register plus writeback-source select; successor to the 16-bit combinational writeback mux.
- Registers the memory-stage result, then picks one of four sources: ALU, memory, link PC or immediate.
- Drives the register-file write port and the WB-stage forwarding taps.
- Adds stall hold with write-once semantics, flush, link-register override and a sticky halt.

Parameters:
- DATA_W, 16, datapath width of all data ports.
- REG_ADDR_W, 3, register-specifier width.
- LINK_REG, 7, destination forced for link writes; must fit REG_ADDR_W.
- CNT_W, 16, retire-counter width; used only with the optional feature.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a valid instruction this cycle.
- stall  in  1  hold the current WB entry; ignore upstream.
- flush  in  1  kill the current WB entry and the incoming one.
- alu_out  in  DATA_W  ALU result.
- mem_data  in  DATA_W  data-memory read data.
- pc_next  in  DATA_W  PC+2 of the instruction, used for link writes.
- imm_data  in  DATA_W  immediate for load-immediate ops.
- wb_sel  in  2  source select: 00 ALU, 01 mem, 10 link (pc_next), 11 imm.
- reg_wr_in  in  1  instruction writes the register file.
- wr_reg_in  in  REG_ADDR_W  destination register.
- halt_in  in  1  instruction is HALT.
- wb_valid  out  1  WB register holds a live entry.
- wb_reg_wr_en  out  1  register-file write enable.
- wb_wr_reg  out  REG_ADDR_W  register-file write address.
- wb_data  out  DATA_W  register-file write data.
- wb_halted  out  1  sticky: a HALT has retired.
- retire_count  out  CNT_W  retired-instruction count.

Behaviour:
- Latency: one cycle from upstream inputs to all wb_* outputs. Outputs derive only from registered state; no input-to-output combinational path.
- Input capture: the data mux is resolved at capture and stored as a single DATA_W value.
  - 00 = alu_out, 01 = mem_data, 10 = pc_next, 11 = imm_data.
  - wb_sel=10 forces the stored destination to LINK_REG, regardless of wr_reg_in.
- Register update priority per edge: rst > flush > halted > stall > load.
  - rst: clear valid, data, destination, write flag, halted and counter. All outputs read 0.
  - flush: valid becomes 0. Stored data is don't-care; halted is unchanged.
  - halted=1: valid becomes 0 and all later inputs are ignored until rst.
  - stall: all fields hold, including valid.
  - otherwise: load valid=in_valid and the captured fields.
- Write-once rule:
  - A presented flag is set on the first cycle an entry is visible and cleared on every load, flush or rst.
  - wb_reg_wr_en = valid & stored reg_wr & ~presented.
  - A stalled entry therefore writes the register file exactly once.
  - wb_wr_reg and wb_data stay stable while held.
- Retire event = valid & ~presented.
  - If the entry's halt bit is set, wb_halted goes 1 the next edge and stays 1 until rst.
  - The HALT entry itself still performs its register write (if reg_wr) in its retire cycle.
- Simultaneous events:
  - flush with stall: flush wins.
  - flush in the same cycle a HALT entry retires: the retire is already complete (the retire event is combinational on current state), so halted still sets.
  - in_valid=0 without stall: a bubble loads, wb_valid=0.
- Reset mid-stall: the held entry is discarded with no write.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
- Defined: retire_count increments by 1 on each retire event and saturates at all-ones (no wrap). It is cleared by rst and unaffected by flush.
- Undefined: no counter logic; retire_count is tied to 0.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all outputs 0; wb_halted=0; retire_count=0.
- Select: in_valid=1, reg_wr=1, wr_reg=3, alu=0x1111, mem=0x2222, pc_next=0x0044, imm=0xFFF0.
  - Sweep wb_sel 00,01,10,11 -> next cycle wb_data 0x1111/0x2222/0x0044/0xFFF0.
  - wb_wr_reg is 3, except 7 for sel=10.
- Stall hold: load entry (wr_reg=2, data 0xBEEF), then stall 3 cycles -> wb_reg_wr_en high exactly 1 cycle; wb_data 0xBEEF for all 4 cycles; retire_count +1.
- Flush: flush together with stall and in_valid=1 -> next cycle wb_valid=0 and wb_reg_wr_en=0; the following load behaves normally.
- Halt: valid HALT with reg_wr=0, then 5 valid ALU writes -> wb_halted=1 from the cycle after the HALT's retire cycle; no further wb_reg_wr_en; rst clears wb_halted.
- Counter (WB_RETIRE_COUNT_EN): CNT_W=4, retire 20 entries -> retire_count reaches 15 and holds.
